// File: rtl/sti_dac_pkg.sv
// Shared constants, FSM encoding and frame builder for the sti_dac serial
// transmitter / pixel arrangement controller.
package sti_dac_pkg;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  localparam int PIX_TOTAL  = 256;
  localparam int BANK_DEPTH = 32;
  localparam int ADDR_W     = $clog2(BANK_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, FILL, DONE} state_t;

  // Right-aligned frame: only bits [N-1:0] are ever shifted out.
  function automatic logic [31:0] build_frame(input logic [15:0] data,
                                              input logic [1:0]  len,
                                              input logic        fill,
                                              input logic        low);
    logic [31:0] f;
    f = '0;
    case (len)
      LEN_8:   f = {24'h0, (low ? data[15:8] : data[7:0])};
      LEN_16:  f = {16'h0, data};
      LEN_24:  f = fill ? {8'h0, data, 8'h00} : {16'h0, data};
      LEN_32:  f = fill ? {data, 16'h0000} : {16'h0000, data};
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sti_dac_map.sv
// Pixel index to memory location: bank from n[7:6], address from n[5:1],
// odd/even checkerboard from n[0]^n[3], decoded into one-hot write selects.
module sti_dac_map
  import sti_dac_pkg::*;
(
  input  logic [7:0]        pix_n,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wr_sel
);

  logic [1:0] bank;
  logic       is_even;
  logic [2:0] slot;

  assign bank    = pix_n[7:6];
  assign is_even = pix_n[0] ^ pix_n[3];
  assign addr    = pix_n[5:1];
  assign slot    = {is_even, bank};

  // wr_sel[3:0] = odd1..odd4, wr_sel[7:4] = even1..even4
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
      assign wr_sel[gi] = (slot == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/sti_dac.sv
// Serializer plus pixel packer/distributor. Define PIXEL_DBG_EN to expose
// pixel_wr / pixel_addr / pixel_dataout / pixel_finish debug outputs.
module sti_dac
  import sti_dac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  input  logic        pi_end,
  output logic        so_data,
  output logic        so_valid,
  output logic [4:0]  oem_addr,
  output logic [7:0]  oem_dataout,
  output logic        odd1_wr,
  output logic        odd2_wr,
  output logic        odd3_wr,
  output logic        odd4_wr,
  output logic        even1_wr,
  output logic        even2_wr,
  output logic        even3_wr,
  output logic        even4_wr,
  output logic        oem_finish
`ifdef PIXEL_DBG_EN
  ,
  output logic        pixel_wr,
  output logic [7:0]  pixel_addr,
  output logic [7:0]  pixel_dataout,
  output logic        pixel_finish
`endif
);

  state_t      state_reg;
  logic [31:0] frame_reg;
  logic [1:0]  len_reg;
  logic        msb_reg;
  logic [5:0]  bit_idx_reg;
  logic [7:0]  pix_sh_reg;
  logic [2:0]  sub_cnt_reg;
  logic [7:0]  pix_cnt_reg;
  logic        fill_gap_reg;
  logic [7:0]  wr_pend_reg;
  logic [7:0]  wr_reg;

  logic [4:0]  last_idx;
  logic [4:0]  sel_idx;
  logic        word_done;
  logic        cur_bit;
  logic [7:0]  send_byte;
  logic [7:0]  fill_byte;
  logic        emit;
  logic [7:0]  emit_byte;
  logic        last_pix;
  logic [4:0]  map_addr;
  logic [7:0]  map_sel;

  always_comb begin
    last_idx  = {len_reg, 3'b111};
    word_done = (bit_idx_reg == ({1'b0, last_idx} + 6'd1));
    sel_idx   = msb_reg ? (last_idx - bit_idx_reg[4:0]) : bit_idx_reg[4:0];
    cur_bit   = frame_reg[sel_idx];
    send_byte = {pix_sh_reg[6:0], cur_bit};
    // A partial byte keeps its bits in the MSBs and is padded with zeros.
    fill_byte = pix_sh_reg << (4'd8 - {1'b0, sub_cnt_reg});
    emit      = ((state_reg == SEND) && !word_done && (sub_cnt_reg == 3'd7)) ||
                ((state_reg == FILL) && !fill_gap_reg);
    emit_byte = (state_reg == FILL) ? fill_byte : send_byte;
    last_pix  = (pix_cnt_reg == 8'(PIX_TOTAL - 1));
  end

  sti_dac_map u_map (
    .pix_n  (pix_cnt_reg),
    .addr   (map_addr),
    .wr_sel (map_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      frame_reg    <= '0;
      len_reg      <= LEN_8;
      msb_reg      <= 1'b0;
      bit_idx_reg  <= '0;
      pix_sh_reg   <= '0;
      sub_cnt_reg  <= '0;
      pix_cnt_reg  <= '0;
      fill_gap_reg <= 1'b0;
      wr_pend_reg  <= '0;
      wr_reg       <= '0;
      so_data      <= 1'b0;
      so_valid     <= 1'b0;
      oem_addr     <= '0;
      oem_dataout  <= '0;
      oem_finish   <= 1'b0;
    end else begin
      // Address/data land one cycle ahead of the strobe they belong to.
      wr_reg      <= wr_pend_reg;
      wr_pend_reg <= '0;
      case (state_reg)
        IDLE: begin
          so_valid <= 1'b0;
          if (load) begin
            frame_reg   <= build_frame(pi_data, pi_length, pi_fill, pi_low);
            len_reg     <= pi_length;
            msb_reg     <= pi_msb;
            bit_idx_reg <= '0;
            state_reg   <= SEND;
          end else if (pi_end) begin
            fill_gap_reg <= 1'b0;
            state_reg    <= FILL;
          end
        end
        SEND: begin
          if (word_done) begin
            so_valid  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            so_valid    <= 1'b1;
            so_data     <= cur_bit;
            bit_idx_reg <= bit_idx_reg + 6'd1;
            pix_sh_reg  <= send_byte;
            sub_cnt_reg <= sub_cnt_reg + 3'd1;
          end
        end
        FILL: begin
          fill_gap_reg <= !fill_gap_reg;
          if (!fill_gap_reg) begin
            sub_cnt_reg <= '0;
            pix_sh_reg  <= '0;
          end
        end
        DONE: begin
          so_valid <= 1'b0;
          if (wr_pend_reg == '0) oem_finish <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
      if (emit) begin
        oem_addr    <= map_addr;
        oem_dataout <= emit_byte;
        wr_pend_reg <= map_sel;
        pix_cnt_reg <= pix_cnt_reg + 8'd1;
        if (last_pix) state_reg <= DONE;
      end
    end
  end

  assign {even4_wr, even3_wr, even2_wr, even1_wr,
          odd4_wr, odd3_wr, odd2_wr, odd1_wr} = wr_reg;

`ifdef PIXEL_DBG_EN
  logic [7:0] dbg_n_reg;

  always_ff @(posedge clk) begin
    if (reset)     dbg_n_reg <= '0;
    else if (emit) dbg_n_reg <= pix_cnt_reg;
  end

  assign pixel_wr      = |wr_reg;
  assign pixel_addr    = dbg_n_reg;
  assign pixel_dataout = oem_dataout;
  assign pixel_finish  = oem_finish;
`endif

endmodule

// File: tb/tb_sti_dac.sv
// Scoreboard bench for sti_dac: stimulus pushes expected serial bits, word
// lengths and memory writes; a negedge monitor pops and compares them.
module tb_sti_dac;

  logic        clk = 1'b0;
  logic        reset, load, pi_fill, pi_msb, pi_low, pi_end;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        so_data, so_valid, oem_finish;
  logic [4:0]  oem_addr;
  logic [7:0]  oem_dataout;
  logic        odd1_wr, odd2_wr, odd3_wr, odd4_wr;
  logic        even1_wr, even2_wr, even3_wr, even4_wr;

  always #5 clk = ~clk;

  sti_dac dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .so_data(so_data), .so_valid(so_valid),
    .oem_addr(oem_addr), .oem_dataout(oem_dataout),
    .odd1_wr(odd1_wr), .odd2_wr(odd2_wr), .odd3_wr(odd3_wr), .odd4_wr(odd4_wr),
    .even1_wr(even1_wr), .even2_wr(even2_wr), .even3_wr(even3_wr),
    .even4_wr(even4_wr), .oem_finish(oem_finish)
  );

  typedef struct {int n; int slot; int addr; int data;} wr_t;

  int  exp_bits[$];
  int  exp_lens[$];
  wr_t exp_wr[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  m_acc, m_nb, m_n;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // slot: 0..3 = odd1..odd4, 4..7 = even1..even4
  function automatic void model_pixel(input int data);
    wr_t w;
    if (m_n < 256) begin
      w.n    = m_n;
      w.slot = (((m_n % 2) != ((m_n / 8) % 2)) ? 4 : 0) + m_n / 64;
      w.addr = (m_n % 64) / 2;
      w.data = data;
      exp_wr.push_back(w);
      m_n++;
    end
  endfunction

  function automatic void model_bit(input int b);
    exp_bits.push_back(b);
    m_acc = ((m_acc << 1) | b) & 255;
    m_nb++;
    if (m_nb == 8) begin
      model_pixel(m_acc);
      m_nb = 0;
      m_acc = 0;
    end
  endfunction

  function automatic void model_clear();
    exp_bits.delete();
    exp_lens.delete();
    exp_wr.delete();
    m_acc = 0;
    m_nb = 0;
    m_n = 0;
  endfunction

  task automatic do_load(input logic [15:0] data, input logic [1:0] len,
                         input logic fill, input logic msb, input logic low,
                         input bit wait_done);
    int nbits;
    logic [31:0] f;
    nbits = (int'(len) + 1) * 8;
    case (len)
      2'd0:    f = {24'h0, (low ? data[15:8] : data[7:0])};
      2'd1:    f = {16'h0, data};
      2'd2:    f = fill ? ({16'h0, data} << 8) : {16'h0, data};
      default: f = fill ? ({16'h0, data} << 16) : {16'h0, data};
    endcase
    exp_lens.push_back(nbits);
    for (int i = 0; i < nbits; i++)
      model_bit(msb ? int'(f[nbits - 1 - i]) : int'(f[i]));
    @(negedge clk);
    load = 1'b1; pi_data = data; pi_length = len; pi_fill = fill;
    pi_msb = msb; pi_low = low;
    @(negedge clk);
    load = 1'b0;
    if (wait_done) repeat (nbits + 1) @(negedge clk);
  endtask

  task automatic wait_finish(input string name, input int budget);
    for (int i = 0; i < budget && !oem_finish; i++) @(negedge clk);
    check(name, oem_finish, 1);
  endtask

  // Monitor
  int         run = 0;
  logic [4:0] prev_addr = '0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    logic [7:0] strobes;
    wr_t w;
    int act_slot;
    strobes = {even4_wr, even3_wr, even2_wr, even1_wr,
               odd4_wr, odd3_wr, odd2_wr, odd1_wr};
    if (reset) begin
      run = 0;
    end else begin
      if (so_valid) begin
        run++;
        check("so_data", so_data, (exp_bits.size() > 0) ? exp_bits.pop_front() : 2);
      end else if (run > 0) begin
        check("valid_len", run, (exp_lens.size() > 0) ? exp_lens.pop_front() : -1);
        run = 0;
      end
      if (strobes != 8'h0) begin
        if (exp_wr.size() > 0) w = exp_wr.pop_front();
        else begin w.n = -1; w.slot = -1; w.addr = -1; w.data = -1; end
        act_slot = -1;
        for (int i = 0; i < 8; i++) if (strobes[i] && act_slot < 0) act_slot = i;
        check("wr_onehot", $countones(strobes), 1);
        check("wr_hold", {oem_addr, oem_dataout}, {prev_addr, prev_data});
        check("finish_early", oem_finish, 0);
        check($sformatf("wr_bank n=%0d", w.n), act_slot, w.slot);
        check($sformatf("wr_addr n=%0d", w.n), oem_addr, w.addr);
        check($sformatf("wr_data n=%0d", w.n), oem_dataout, w.data);
      end
      prev_addr = oem_addr;
      prev_data = oem_dataout;
    end
  end

  initial begin
    reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_state", {so_data, so_valid, oem_addr, oem_dataout,
          odd1_wr, odd2_wr, odd3_wr, odd4_wr, even1_wr, even2_wr, even3_wr,
          even4_wr, oem_finish}, 0);
    reset = 1'b0;

    // Directed words, then random words until ~96 pixels are queued.
    do_load(16'hA5C3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    do_load(16'hA5C3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    do_load(16'h1234, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    do_load(16'hBEEF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    while (m_n < 96)
      do_load(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
              1'($urandom), 1'($urandom), 1'b1);

    @(negedge clk);
    pi_end = 1'b1;
    if (m_nb > 0) model_pixel((m_acc << (8 - m_nb)) & 255);
    while (m_n < 256) model_pixel(0);
    wait_finish("finish_after_fill", 1500);
    repeat (20) @(negedge clk);
    check("finish_held", oem_finish, 1);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("bit_queue_empty", exp_bits.size(), 0);

    // Reset in the middle of a word.
    reset = 1'b1; pi_end = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_load(16'h5AF0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check("midstream_reset", {so_data, so_valid, oem_addr, oem_dataout,
          odd1_wr, odd2_wr, odd3_wr, odd4_wr, even1_wr, even2_wr, even3_wr,
          even4_wr, oem_finish}, 0);
    @(negedge clk);
    reset = 1'b0;

    // 256 pixels from 32-bit words without pi_end: finish anyway.
    for (int i = 0; i < 64; i++)
      do_load(16'($urandom), 2'b11, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    wait_finish("finish_full_stream", 50);
    repeat (10) @(negedge clk);
    check("finish_full_held", oem_finish, 1);
    check("full_wr_queue_empty", exp_wr.size(), 0);
    check("full_bit_queue_empty", exp_bits.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
